// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction issue path.
package cpu_pkg;

    // Instruction word width seen by the CPU core.
    localparam int INSTR_W = 9;

    // Issue FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_t;

    // Value presented on INSTRUCTION before anything has been issued.
    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

endpackage

// File: rtl/instr_fifo.sv
// Circular-buffer word FIFO. A push is accepted when the FIFO is not full,
// or when a pop happens in the same cycle (the freed slot is reused).
module instr_fifo #(
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [INSTR_W-1:0]       push_data,
    input  logic                     pop,
    output logic [INSTR_W-1:0]       pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               accept;
    logic               do_pop;

    assign do_pop   = pop && !empty;
    assign accept   = push && (!full || do_pop);
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Serial-to-word instruction loader: deserialises LSB-first bits into words,
// buffers them, and issues them to the CPU core as INSTRUCTION + write_en,
// paced by a fixed inter-issue gap and gated by HALT.
//
// Handshake: write_en is a one-cycle strobe with no back-pressure; the core
// must take INSTRUCTION in every cycle where write_en is 1. On the input side
// SVALID qualifies SDATA on each rising edge; there is no ready, and a word
// completing while the FIFO is full (with no simultaneous pop) is dropped and
// recorded in the sticky OVF flag.
module instr_loader #(
    parameter int INSTR_W    = 9,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SDATA,
    input  logic                     SVALID,
    input  logic                     ABORT,
    input  logic                     HALT,
    output logic [INSTR_W-1:0]       INSTRUCTION,
    output logic                     write_en,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVF,
    output logic                     BUSY,
    output logic [1:0]               dbg_state
);

    import cpu_pkg::*;

    localparam int BW = $clog2(INSTR_W);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(INSTR_W - 1);

    // Deserialiser state
    logic [INSTR_W-1:0] shreg;
    logic [BW-1:0]      bitcnt;
    logic               word_done;
    logic [INSTR_W-1:0] word;

    // FIFO interface
    logic               pop;
    logic [INSTR_W-1:0] pop_data;
    logic               fifo_full;
    logic               fifo_empty;

    // Issue FSM
    issue_state_t       state;
    issue_state_t       state_n;
    logic [GW-1:0]      gap_cnt;
    logic [GW-1:0]      gap_cnt_n;
    logic               can_pop;

    // The last bit is taken straight from SDATA so the word is complete on its edge.
    assign word_done = SVALID && !ABORT && (bitcnt == LAST_BIT);
    assign word      = {SDATA, shreg[INSTR_W-2:0]};

    // Shift SDATA into bit position bitcnt; ABORT drops any partial word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (ABORT) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (SVALID) begin
            shreg[bitcnt] <= SDATA;
            if (bitcnt == LAST_BIT) begin
                bitcnt <= '0;
            end else begin
                bitcnt <= bitcnt + BW'(1);
            end
        end
    end

    instr_fifo #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (word_done),
        .push_data (word),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (LEVEL)
    );

    assign can_pop = !fifo_empty && !HALT;

    // Issue FSM state and gap counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_cnt_n;
        end
    end

    // Next-state logic. The last GAP cycle may pop directly so that strobes
    // are spaced exactly GAP_CYCLES+1 apart.
    always_comb begin
        state_n   = state;
        gap_cnt_n = gap_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = GW'(GAP_CYCLES);
                    state_n   = GAP;
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt - GW'(1);
                if (gap_cnt <= GW'(1)) begin
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // INSTRUCTION is loaded on the pop edge and holds between strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INSTRUCTION <= INSTR_NOP;
        end else if (pop) begin
            INSTRUCTION <= pop_data;
        end
    end

    // Sticky overflow: a completed word found the FIFO full with no pop to free a slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OVF <= 1'b0;
        end else if (word_done && fifo_full && !pop) begin
            OVF <= 1'b1;
        end
    end

    assign write_en  = (state == ISSUE);
    assign FULL      = fifo_full;
    assign EMPTY     = fifo_empty;
    assign BUSY      = (state != IDLE) || !fifo_empty;
    assign dbg_state = state;

endmodule
